// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between the read-only
// instruction-fetch bus and the MEM-stage data bus. CPU-side level requests
// are turned into a registered req/ack handshake toward memory; read data
// and stall release go only to the master that owns the transaction.
//
// Optional build macro ARB_ROUND_ROBIN_EN: when both masters are pending,
// grant the one not served by the most recent transaction. Without it the
// data bus always wins (fetch may starve under back-to-back data traffic).
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ib_address,
  input  logic              ib_read,
  output logic [DATA_W-1:0] ib_data_rd,
  output logic              ib_stall,
  input  logic [ADDR_W-1:0] db_address,
  input  logic              db_read,
  input  logic              db_write,
  input  logic [DATA_W-1:0] db_data_wr,
  input  logic [3:0]        db_mask,
  output logic [DATA_W-1:0] db_data_rd,
  output logic              db_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } own_t;

  // Clears the byte offset so memory always sees a word-aligned address.
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t state, state_nxt;
  own_t   own;

  logic              d_pend, i_pend, grant_any, grant_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;

  assign d_pend    = db_read | db_write;
  assign i_pend    = ib_read;
  assign grant_any = d_pend | i_pend;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> WAIT on any grant, WAIT -> RESP on ack,
  // RESP lasts exactly one cycle. mem_ack is ignored outside WAIT.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (grant_any) state_nxt = S_WAIT;
      S_WAIT:  if (mem_ack)   state_nxt = S_RESP;
      S_RESP:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Output logic: arbitration, request selection and per-master stall.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On contention, hand the port to whoever was not served last.
    grant_d = d_pend & (~i_pend | (own == OWN_I));
`else
    // Fixed priority: the data bus always wins.
    grant_d = d_pend;
`endif
    if (grant_d) begin
      // Simultaneous read and write is treated as a write.
      sel_we    = db_write;
      sel_addr  = db_address & WORD_MASK;
      sel_wdata = db_data_wr;
      sel_be    = db_mask;
    end else begin
      sel_we    = 1'b0;
      sel_addr  = ib_address & WORD_MASK;
      sel_wdata = '0;
      sel_be    = 4'hF;
    end
    ib_stall = ib_read & ~((state == S_RESP) && (own == OWN_I));
    db_stall = d_pend  & ~((state == S_RESP) && (own == OWN_D));
  end

  // Memory-side request registers, owner and read-data capture.
  // NOTE: the read-data registers are reset too: they are architecturally
  // visible outputs and must come up as zero, not X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own        <= OWN_I;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'h0;
      ib_data_rd <= '0;
      db_data_rd <= '0;
    end else begin
      if ((state == S_IDLE) && grant_any) begin
        own       <= grant_d ? OWN_D : OWN_I;
        mem_req   <= 1'b1;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_be    <= sel_be;
      end else if ((state == S_WAIT) && mem_ack) begin
        // Request fields stay put; only req drops. Writes leave read data alone.
        mem_req <= 1'b0;
        if (!mem_we) begin
          if (own == OWN_D) begin
            db_data_rd <= mem_rdata;
          end else begin
            ib_data_rd <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
